// File: rtl/sr_pkg.sv
// Shared definitions for the switch debounce / SR latch driver.
// State encoding is 3-bit binary; clog2 sizes the counters without relying on $clog2.
package sr_pkg;

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_LOW       = 3'd1,
    ST_CHK_HIGH  = 3'd2,
    ST_PULSE_S   = 3'd3,
    ST_HIGH      = 3'd4,
    ST_CHK_LOW   = 3'd5,
    ST_PULSE_R   = 3'd6
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sr_debounce_driver_sync2.sv
// Purpose: two-flop synchroniser for an asynchronous level; resets to 0.
// Latency: 2 clk cycles. Backpressure: none, free-running.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sr_debounce_driver.sv
// Purpose: debounce a raw switch and emit clean set/reset pulses for a NOR SR latch.
// Latency: pulse starts 3+DEBOUNCE_CYCLES edges after din settles. Backpressure: none.
module sr_debounce_driver
  import sr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic s,
  output logic r,
  output logic level,
  output logic busy
);

  localparam int CW = clog2(DEBOUNCE_CYCLES);
  localparam int PW = clog2(PULSE_CYCLES + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_FULL = PW'(PULSE_CYCLES);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   pcnt;
  logic            din_sync;

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (din_sync)
  );

  // Outputs are registered alongside the state so they always reflect the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
      cnt   <= '0;
      pcnt  <= '0;
      s     <= 1'b0;
      r     <= 1'b0;
      level <= 1'b0;
      busy  <= 1'b1;
    end else begin
      case (state)
        // r is still low on the first edge out of reset, so INIT counts to the full width.
        ST_INIT: begin
          if (pcnt == PULSE_FULL) begin
            state <= ST_LOW;
            pcnt  <= '0;
            r     <= 1'b0;
            busy  <= 1'b0;
          end else begin
            pcnt <= pcnt + 1'b1;
            r    <= 1'b1;
          end
        end

        ST_LOW: begin
          if (din_sync) begin
            state <= ST_CHK_HIGH;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        ST_CHK_HIGH: begin
          if (!din_sync) begin
            state <= ST_LOW;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_PULSE_S;
            cnt   <= '0;
            pcnt  <= '0;
            s     <= 1'b1;
            level <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_PULSE_S: begin
          if (pcnt == PULSE_LAST) begin
            state <= ST_HIGH;
            pcnt  <= '0;
            s     <= 1'b0;
            busy  <= 1'b0;
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end

        ST_HIGH: begin
          if (!din_sync) begin
            state <= ST_CHK_LOW;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        ST_CHK_LOW: begin
          if (din_sync) begin
            state <= ST_HIGH;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_PULSE_R;
            cnt   <= '0;
            pcnt  <= '0;
            r     <= 1'b1;
            level <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_PULSE_R: begin
          if (pcnt == PULSE_LAST) begin
            state <= ST_LOW;
            pcnt  <= '0;
            r     <= 1'b0;
            busy  <= 1'b0;
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end

        default: begin
          state <= ST_INIT;
          cnt   <= '0;
          pcnt  <= '0;
          s     <= 1'b0;
          r     <= 1'b0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule
